fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one `fifo` instance between NREQ producers (e.g. UART TX, debug port, DMA).
- Each producer presents a valid/ready stream; the arbiter grants one producer at a time for a bounded burst and drives the FIFO's `wr`/`din` directly.
- It respects the FIFO's `full` flag, so no push is ever issued into a full FIFO.

Parameters:
- NREQ, 4, number of requesters (>= 2)
- DATA_WIDTH, 32, word width; must match the FIFO data width
- BURST, 4, maximum words accepted per grant before rotating (>= 1)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- req_valid  input  NREQ  bit i set: requester i has a word on its data slice
- req_data  input  NREQ*DATA_WIDTH  requester i's word at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NREQ  bit i set: requester i's word is accepted this cycle
- fifo_full  input  1  from the FIFO `full` output
- fifo_wr  output  1  to the FIFO `wr` input
- fifo_din  output  DATA_WIDTH  to the FIFO `din` input
- grant_valid  output  1  a requester currently owns the FIFO
- grant_id  output  $clog2(NREQ)  index of the current owner

Behaviour:
- Registered state:
  - state: IDLE or BUSY
  - owner ($clog2(NREQ) bits)
  - burst_cnt ($clog2(BURST)+1 bits)
- Reset (rst low, asynchronous): state=IDLE, owner=NREQ-1, burst_cnt=0. All outputs are 0 immediately, without waiting for a clock edge.
- Search function: first i with req_valid[i]=1, scanning owner+1, owner+2, ... owner, modulo NREQ. The current owner is checked last.
- IDLE:
  - If any req_valid bit is set: next state BUSY, owner=search result, burst_cnt=0.
  - Otherwise stay IDLE.
  - Grant latency is 1 cycle after req_valid rises.
- BUSY outputs (combinational from state):
  - grant_valid=1, grant_id=owner
  - req_ready[owner] = ~fifo_full; all other req_ready bits are 0
  - fifo_wr = req_valid[owner] & ~fifo_full
  - fifo_din = req_data slice of owner
- IDLE outputs: fifo_wr=0, req_ready=0, fifo_din=0, grant_valid=0, grant_id=owner.
- Transfer: occurs when req_valid[owner] & req_ready[owner]. It is the same cycle the FIFO samples wr=1; burst_cnt increments.
- Release, in BUSY, when either:
  - (a) a transfer occurs with burst_cnt==BURST-1, or
  - (b) req_valid[owner]=0, whether or not fifo_full is set.
- On release, re-arbitrate in the same cycle with the search function:
  - If a requester is found: stay BUSY with the new owner and burst_cnt=0. There is no bubble, and the same owner may be re-granted if it is the only requester valid.
  - If none is found: go to IDLE; owner is retained so rotation continues from it.
- fifo_full stall: no transfer, burst_cnt holds, grant is held while the owner stays valid. There is no timeout.
- Requester contract: a requester must hold req_valid and its data stable until it sees ready. The arbiter does not buffer data.
- Simultaneous requests: resolved strictly by rotation; lower index wins only relative to the rotation pointer.
- Reset mid-burst: grant aborted, no partial state kept. After release, the first grant goes to the lowest valid index because owner resets to NREQ-1.

Test Plan:
- Reset: assert rst low mid-operation -> req_ready=0, fifo_wr=0, grant_valid=0, grant_id=0 before the next clk edge.
- Single requester: req 2 streams 0..9 with continuous valid -> grant_id=2 one cycle after valid rises. FIFO receives 0..9 in order on consecutive edges; one re-grant every 4 words with no bubble.
- Fairness: req 0 and req 3 both continuously valid with distinct data -> FIFO receives 4 words from 0, 4 from 3, 4 from 0, ...; grant_id toggles 0,3,0.
- Full stall: fifo_full high for 3 cycles after the 2nd word of a burst -> fifo_wr=0 and req_ready=0 for those 3 cycles. Exactly 2 more words follow, then rotation.
- Early release: owner 1 drops valid after 2 words while req 2 is valid -> grant_id=2 on the next cycle; req 1 loses no words and no duplicate is pushed.
- FIFO integration: connect to a 32-deep `fifo`, 3 requesters push 40 words total -> pushes stop while `full`=1. After popping all entries, each requester's words appear in its own order, and the total is 40.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: grants one valid/ready producer at a time,
// for bursts of at most BURST words, and drives the FIFO write port directly.
module fifo_wr_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BURST      = 4,
    localparam int IDW       = $clog2(NREQ),
    localparam int CW        = $clog2(BURST) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wr,
    output logic [DATA_WIDTH-1:0]      fifo_din,
    output logic                       grant_valid,
    output logic [IDW-1:0]             grant_id
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [CW-1:0]   burst_cnt_q, burst_cnt_d;

    logic                  found;
    logic [IDW-1:0]        pick;
    logic                  owner_valid;
    logic [DATA_WIDTH-1:0] owner_data;
    logic                  xfer;
    logic                  burst_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= IDW'(NREQ - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Rotating search: owner+1 first, the current owner last.
    always_comb begin : search_p
        int idx;
        found = 1'b0;
        pick  = owner_q;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(owner_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
    end

    assign owner_valid = req_valid[owner_q];
    assign owner_data  = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
    assign xfer        = (state_q == BUSY) && owner_valid && !fifo_full;
    assign burst_last  = (burst_cnt_q == CW'(BURST - 1));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = BUSY;
                    owner_d     = pick;
                    burst_cnt_d = '0;
                end
            end
            BUSY: begin
                if (!owner_valid || (xfer && burst_last)) begin
                    // Re-arbitrate in the release cycle so there is no bubble.
                    burst_cnt_d = '0;
                    if (found) begin
                        owner_d = pick;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // Outputs are gated by rst so they read zero as soon as reset asserts.
    always_comb begin
        req_ready   = '0;
        fifo_wr     = 1'b0;
        fifo_din    = '0;
        grant_valid = 1'b0;
        grant_id    = '0;
        if (rst) begin
            grant_id = owner_q;
            if (state_q == BUSY) begin
                grant_valid        = 1'b1;
                req_ready[owner_q] = !fifo_full;
                fifo_wr            = owner_valid && !fifo_full;
                fifo_din           = owner_data;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench: producers with queued sequence-tagged words, a cycle-level
// reference of the rotation rules, and a per-source push scoreboard.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 32;
    localparam int BURST = 4;
    localparam int IDW   = $clog2(NREQ);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*DW-1:0]   req_data = '0;
    logic [NREQ-1:0]      req_ready;
    logic                 fifo_full = 1'b0;
    logic                 fifo_wr;
    logic [DW-1:0]        fifo_din;
    logic                 grant_valid;
    logic [IDW-1:0]       grant_id;

    fifo_wr_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .BURST(BURST)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_din(fifo_din),
        .grant_valid(grant_valid), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // producer side
    bit pv[NREQ];
    int seq[NREQ];
    int left[NREQ];
    int prob[NREQ];
    int full_pct = 0;
    int pushes = 0;
    int expected_total = 0;

    // reference arbiter
    bit m_busy;
    int m_owner;
    int m_cnt;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int next_owner(int from, logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++)
            if (v[(from + k) % NREQ]) return (from + k) % NREQ;
        return -1;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < NREQ; i++) begin
            if (!pv[i] && left[i] > 0 && $urandom_range(99) < prob[i]) pv[i] = 1'b1;
            req_valid[i] = pv[i];
            req_data[i*DW +: DW] = {8'(i), 24'(seq[i])};
        end
        fifo_full = ($urandom_range(99) < full_pct);
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = NREQ - 1;
        m_cnt   = 0;
    endtask

    task automatic cycle();
        logic [NREQ-1:0] exp_ready;
        logic            exp_wr;
        logic [DW-1:0]   exp_din;
        int              nxt;
        @(negedge clk);
        exp_ready = '0;
        exp_wr    = 1'b0;
        exp_din   = '0;
        if (m_busy) begin
            if (!fifo_full) exp_ready[m_owner] = 1'b1;
            exp_wr  = req_valid[m_owner] && !fifo_full;
            exp_din = {8'(m_owner), 24'(seq[m_owner])};
        end
        check("grant_valid", grant_valid, m_busy);
        check("grant_id", grant_id, m_owner);
        check("req_ready", req_ready, exp_ready);
        check("fifo_wr", fifo_wr, exp_wr);
        check("fifo_din", fifo_din, exp_din);
        if (exp_wr) begin
            check("push_src", fifo_din[31:24], m_owner);
            check("push_seq", fifo_din[23:0], seq[m_owner]);
            $display("push src=%0d seq=%0d burst_word=%0d", m_owner, seq[m_owner], m_cnt);
            pushes++;
            seq[m_owner]++;
            left[m_owner]--;
            pv[m_owner] = 1'b0;
        end
        // next owner per rotation rules
        if (!m_busy) begin
            nxt = next_owner(m_owner, req_valid);
            if (nxt >= 0) begin
                m_busy = 1'b1; m_owner = nxt; m_cnt = 0;
            end
        end else begin
            if (exp_wr) m_cnt++;
            if (!req_valid[m_owner] || (exp_wr && m_cnt == BURST)) begin
                nxt = next_owner(m_owner, req_valid);
                m_cnt = 0;
                if (nxt >= 0) m_owner = nxt;
                else m_busy = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic load(int id, int words, int p);
        left[id] = left[id] + words;
        prob[id] = p;
        expected_total += words;
    endtask

    task automatic drain(int budget);
        int busy_left;
        busy_left = 1;
        while (busy_left != 0 && budget > 0) begin
            cycle();
            budget--;
            busy_left = 0;
            for (int i = 0; i < NREQ; i++) busy_left += left[i];
        end
        check("drain_timeout", busy_left, 0);
    endtask

    task automatic mid_reset();
        rst = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_fifo_wr", fifo_wr, 0);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_fifo_din", fifo_din, 0);
        model_reset();
        #2;
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            pv[i] = 1'b0; seq[i] = 0; left[i] = 0; prob[i] = 0;
        end
        model_reset();
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_fifo_wr", fifo_wr, 0);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_id", grant_id, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive_inputs();
        repeat (2) cycle();

        // single streaming requester
        load(2, 10, 100);
        drain(100);
        repeat (3) cycle();

        // two continuous requesters alternate in bursts
        load(0, 12, 100);
        load(3, 12, 100);
        drain(200);
        repeat (3) cycle();

        // random valid gaps with back-pressure
        full_pct = 30;
        for (int i = 0; i < NREQ; i++) load(i, 15, 60);
        drain(2000);

        // sparse traffic: frequent early releases
        full_pct = 20;
        for (int i = 0; i < NREQ; i++) load(i, 10, 25);
        repeat (25) cycle();
        mid_reset();
        drain(3000);
        mid_reset();
        full_pct = 0;
        for (int i = 0; i < NREQ; i++) load(i, 6, 80);
        drain(1000);
        repeat (3) cycle();

        check("total_pushes", pushes, expected_total);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
